ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ram_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
// Word-addressed RAM behind a four-phase request/ACK handshake.
//
// A master raises one of the request bits in ctrl_in. The block captures the
// address, the write data and the operation, then waits LATENCY cycles. It
// then performs the access and raises ACK, plus ERR on a fault. ACK stays up
// until the master drops both request bits. One RELEASE cycle follows before
// the next request is accepted.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous reset, active low
//   ctrl_in   : [READ_BIT] read request, [WRITE_BIT] write request,
//               other bits ignored
//   ctrl_out  : [ACK_BIT] access complete, [ERR_BIT] fault, other bits 0
//   addr      : word address (full 32 bits range-checked against DEPTH)
//   data_in   : write data
//   data_out  : read data, held until the next read completes
// ----------------------------------------------------------------------------
module ram_ctrl #(
    parameter int DEPTH     = 4096,
    parameter int LATENCY   = 3,
    parameter int READ_BIT  = 0,
    parameter int WRITE_BIT = 1,
    parameter int ACK_BIT   = 0,
    parameter int ERR_BIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ctrl_in,
    output logic [31:0] ctrl_out,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] DEPTH_W = 33'(DEPTH);
    localparam logic [7:0]  LAT_W   = 8'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [7:0]  cnt_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        is_wr_r;
    logic        err_r;
    logic [31:0] ctrl_out_r;
    logic [31:0] data_out_r;

    // Storage is deliberately left out of reset.
    logic [31:0] mem_r [DEPTH];

    logic        rd_req_s;
    logic        wr_req_s;
    logic        start_s;
    logic        illegal_s;
    logic        complete_s;
    logic        release_s;
    logic        in_range_s;
    logic [AW-1:0] idx_s;
    logic        unused_ctrl_s;

    // Build the status word with only ACK and ERR populated.
    function automatic logic [31:0] status_word(input logic err);
        logic [31:0] s;
        s          = 32'd0;
        s[ACK_BIT] = 1'b1;
        s[ERR_BIT] = err;
        return s;
    endfunction

    assign rd_req_s      = ctrl_in[READ_BIT];
    assign wr_req_s      = ctrl_in[WRITE_BIT];
    // Collects the ctrl_in bits that are intentionally ignored.
    assign unused_ctrl_s = ^ctrl_in;

    // Range check uses the whole captured address; only the low bits index.
    assign in_range_s = ({1'b0, addr_r} < DEPTH_W);
    assign idx_s      = addr_r[AW-1:0];

    assign ctrl_out = ctrl_out_r;
    assign data_out = data_out_r;

    // Next-state decode and single-cycle event strobes for the datapath.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        illegal_s    = 1'b0;
        complete_s   = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!ctrl_out_r[ACK_BIT] && (rd_req_s ^ wr_req_s)) begin
                    next_state_s = ST_BUSY;
                    start_s      = 1'b1;
                end else if (!ctrl_out_r[ACK_BIT] && rd_req_s && wr_req_s) begin
                    next_state_s = ST_DONE;
                    illegal_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Counter reaching zero is observed one edge after the last
                // decrement, giving LATENCY+1 edges from capture to ACK.
                if (cnt_r == 8'd0) begin
                    next_state_s = ST_DONE;
                    complete_s   = 1'b1;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (!rd_req_s && !wr_req_s) begin
                    next_state_s = ST_RELEASE;
                    release_s    = 1'b1;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_RELEASE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture, wait counter, status and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r      <= 8'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            is_wr_r    <= 1'b0;
            err_r      <= 1'b0;
            ctrl_out_r <= 32'd0;
            data_out_r <= 32'd0;
        end else if (start_s) begin
            cnt_r   <= LAT_W;
            addr_r  <= addr;
            wdata_r <= data_in;
            is_wr_r <= wr_req_s;
            err_r   <= 1'b0;
        end else if (illegal_s) begin
            err_r      <= 1'b1;
            ctrl_out_r <= status_word(1'b1);
        end else if (complete_s) begin
            err_r      <= !in_range_s;
            ctrl_out_r <= status_word(!in_range_s);
            if (!is_wr_r) begin
                data_out_r <= in_range_s ? mem_r[idx_s] : 32'd0;
            end
        end else if (state_r == ST_BUSY) begin
            cnt_r <= cnt_r - 8'd1;
        end else if (release_s) begin
            err_r      <= 1'b0;
            ctrl_out_r <= 32'd0;
        end
    end

    // Memory write port; gated by rst so an aborted access never lands.
    always_ff @(posedge clk) begin
        if (rst && complete_s && is_wr_r && in_range_s) begin
            mem_r[idx_s] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
module tb_ram_ctrl;

    localparam int LAT   = 3;
    localparam int DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl_in, ctrl_out, addr, data_in, data_out;
    logic [31:0] ctrl_in1, ctrl_out1, addr1, data_in1, data_out1;

    int errors = 0;
    int checks = 0;

    // Reference model: sparse memory of words known to have been written.
    logic [31:0] model_mem [int unsigned];
    logic [31:0] exp_dout;
    bit          dout_known;

    ram_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out),
        .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    ram_ctrl #(.DEPTH(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in1), .ctrl_out(ctrl_out1),
        .addr(addr1), .data_in(data_in1), .data_out(data_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random junk in the ignored ctrl_in bits, request bits as given.
    task automatic drive_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] c;
        c       = $urandom;
        c[0]    = rd;
        c[1]    = wr;
        ctrl_in = c;
        addr    = a;
        data_in = d;
    endtask

    // One full transaction on the main instance, checked against the model.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input int pre, input bit skip_rel);
        logic [31:0] exp_co;
        bit          e;
        drive_req(rd, wr, a, d);
        for (int i = 0; i < pre; i++) begin
            tick();
            chk("pre_idle", ctrl_out, 32'h0);
        end
        tick();
        if (!(rd && wr)) begin
            for (int i = 0; i <= LAT; i++) begin
                chk("busy_noack", ctrl_out, 32'h0);
                drive_req(rd, wr, $urandom, $urandom);
                tick();
            end
        end
        if (rd && wr) begin
            e = 1'b1;
        end else begin
            e = (a >= 32'(DEPTH));
            if (wr) begin
                if (!e) model_mem[a] = d;
            end else if (e) begin
                exp_dout = 32'h0;
                dout_known = 1'b1;
            end else if (model_mem.exists(a)) begin
                exp_dout = model_mem[a];
                dout_known = 1'b1;
            end else begin
                dout_known = 1'b0;
            end
        end
        exp_co = e ? 32'h3 : 32'h1;
        chk("ack", ctrl_out, exp_co);
        if (dout_known) chk("dout", data_out, exp_dout);
        for (int i = 0; i < hold; i++) begin
            drive_req(rd, wr, $urandom, $urandom);
            tick();
            chk("hold_ack", ctrl_out, exp_co);
        end
        drive_req(1'b0, 1'b0, $urandom, $urandom);
        tick();
        chk("ack_clear", ctrl_out, 32'h0);
        if (dout_known) chk("dout_hold", data_out, exp_dout);
        if (!skip_rel) begin
            tick();
            chk("release", ctrl_out, 32'h0);
        end
    endtask

    initial begin
        int r;
        logic [31:0] a;
        bit rd, wr;

        rst = 1'b0;
        ctrl_in = 32'h0; addr = 32'h0; data_in = 32'h0;
        ctrl_in1 = 32'h0; addr1 = 32'h0; data_in1 = 32'h0;
        exp_dout = 32'h0;
        dout_known = 1'b1;
        repeat (3) tick();
        chk("rst_ctrl_out", ctrl_out, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ctrl_out1", ctrl_out1, 32'h0);

        // First request lands on the first edge with rst high.
        rst = 1'b1;
        do_req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 0, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'd5, 32'h0, 0, 0, 1'b0);

        // Held write: data_in keeps changing during the hold, memory must not.
        do_req(1'b0, 1'b1, 32'd9, 32'h0BAD_F00D, 10, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'd9, 32'h0, 0, 0, 1'b0);

        // Out-of-range read and write; aliasing low bits must stay untouched.
        do_req(1'b0, 1'b1, 32'd4095, 32'h12345678, 0, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'd4096, 32'h0, 0, 0, 1'b0);
        do_req(1'b0, 1'b1, 32'hFFFFFFFF, 32'h1, 0, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'd4095, 32'h0, 0, 0, 1'b0);

        // Both request bits: immediate error, data_out and memory unchanged.
        do_req(1'b1, 1'b0, 32'd5, 32'h0, 0, 0, 1'b0);
        do_req(1'b1, 1'b1, 32'd5, 32'h0, 2, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'd5, 32'h0, 0, 0, 1'b0);

        // Request presented during RELEASE is not taken until IDLE.
        do_req(1'b0, 1'b1, 32'd11, 32'hCAFE0011, 0, 0, 1'b1);
        do_req(1'b1, 1'b0, 32'd11, 32'h0, 0, 1, 1'b0);

        // Reset in the middle of BUSY aborts the write to address 7.
        drive_req(1'b0, 1'b1, 32'd7, 32'h55);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midbusy_rst_ctrl", ctrl_out, 32'h0);
        chk("midbusy_rst_dout", data_out, 32'h0);
        rst = 1'b1;
        exp_dout = 32'h0;
        dout_known = 1'b1;
        do_req(1'b1, 1'b0, 32'd7, 32'h0, 0, 0, 1'b0);
        checks++;
        assert (data_out !== 32'h55) else begin
            errors++;
            $error("FAIL aborted_write: observed=%h expected=not 00000055", data_out);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 19);
            rd = (r == 0) || (r >= 10);
            wr = (r == 0) || (r < 10);
            if ($urandom_range(0, 9) == 0) a = 32'(DEPTH) + 32'($urandom_range(0, 100000));
            else a = 32'($urandom_range(0, 31));
            do_req(rd, wr, a, $urandom, $urandom_range(0, 3), 0, 1'b0);
        end

        // LATENCY=1 instance: ACK two edges after capture, captured values used.
        ctrl_in1 = 32'h2; addr1 = 32'd3; data_in1 = 32'hA5A50003;
        tick();
        chk("l1_wr_busy0", ctrl_out1, 32'h0);
        addr1 = 32'd9; data_in1 = 32'h0;
        tick();
        chk("l1_wr_busy1", ctrl_out1, 32'h0);
        tick();
        chk("l1_wr_ack", ctrl_out1, 32'h1);
        ctrl_in1 = 32'h0;
        tick();
        chk("l1_wr_clear", ctrl_out1, 32'h0);
        tick();
        ctrl_in1 = 32'h1; addr1 = 32'd3;
        tick();
        chk("l1_rd_busy0", ctrl_out1, 32'h0);
        addr1 = 32'd9;
        tick();
        chk("l1_rd_busy1", ctrl_out1, 32'h0);
        tick();
        chk("l1_rd_ack", ctrl_out1, 32'h1);
        chk("l1_rd_data", data_out1, 32'hA5A50003);
        ctrl_in1 = 32'h0;
        tick();
        chk("l1_rd_clear", ctrl_out1, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
